// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a synchronous ROM out over valid/ready through a 2-entry credit FIFO.
// Optional running checksum port cksum when ROM_STREAM_CKSUM_EN is defined.
module rom_stream_reader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_re,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
`ifdef ROM_STREAM_CKSUM_EN
    ,output logic [15:0]      cksum
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr, wr_ptr, in_flight, pop, last, drained, accept;
    logic [1:0]        count, committed;
    assign m_valid   = count != 2'd0;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign pop       = m_valid && m_ready;
    assign last      = rom_addr == ADDR_W'(LAST_ADDR);
    assign drained   = count == 2'd0 && !in_flight;
    assign accept    = state == IDLE && start;
    assign busy      = state != IDLE;
    // Word leaving this cycle frees its slot, so a steady stream keeps one read per cycle.
    assign committed = count - 2'(pop) + 2'(in_flight);
    always_comb begin
        state_nxt = state;
        rom_re    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  state_nxt = start ? RUN : IDLE;
            RUN: begin
                rom_re = !stop && committed < 2'd2;
                if (stop || (rom_re && last && !loop))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                done      = drained;
                state_nxt = drained ? IDLE : DRAIN;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            in_flight <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= rom_re;
            if (accept)
                rom_addr <= '0;
            else if (rom_re)
                rom_addr <= last ? '0 : rom_addr + ADDR_W'(1);
            if (in_flight) begin
                mem[wr_ptr] <= rom_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(in_flight) - 2'(pop);
        end
    end
`ifdef ROM_STREAM_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cksum <= '0;
        else if (accept)
            cksum <= '0;
        else if (pop)
            cksum <= cksum + 16'(m_data);
    end
`endif
endmodule
